uart_ram_loader: RTL



---
 rtl/uart_ram_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_ram_loader.sv
// UART firmware-image loader: packs bytes little-endian into 32-bit RAM words and holds the CPU in reset until the image has landed.
// Optional macro LOADER_CHECKSUM_EN adds a SEND state that transmits the mod-256 byte sum before the CPU is released.
module uart_ram_loader #(
  parameter int unsigned RAM_SIZE = 16'h4000,
  parameter int unsigned ADDR_W   = $clog2(RAM_SIZE / 4)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              sw_uart_upgrade_b,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              cpu_rstb,
  output logic              done
);
  localparam int unsigned CNT_W = $clog2(RAM_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(RAM_SIZE - 1);

  // rx_valid is a one-cycle pulse with no back-pressure; tx_valid is a one-cycle
  // request issued only while tx_busy is low, so a single pulse hands off one byte.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       sum;
  logic [23:0]      word_buf;
  logic             upgrade;

  assign upgrade = !sw_uart_upgrade_b;

`ifndef LOADER_CHECKSUM_EN
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_valid       = 1'b0;
  assign tx_data        = 8'h00;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      sum       <= '0;
      word_buf  <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_rstb  <= 1'b0;
      done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      tx_valid  <= 1'b0;
      tx_data   <= '0;
`endif
    end else begin
      ram_we   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      tx_valid <= 1'b0;
`endif
      cpu_rstb <= (state == IDLE && !upgrade) || state == DONE;
      case (state)
        IDLE: begin
          if (upgrade) begin
            state    <= LOAD;
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        LOAD: begin
          // Abort wins over a coincident byte, which is dropped with the partial word.
          if (!upgrade) begin
            state <= IDLE;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            sum      <= sum + rx_data;
            case (byte_cnt[1:0])
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                ram_we    <= 1'b1;
                ram_addr  <= byte_cnt[ADDR_W+1:2];
                ram_wdata <= {rx_data, word_buf};
                if (byte_cnt == LAST_BYTE) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= SEND;
`else
                  state <= DONE;
                  done  <= 1'b1;
`endif
                end
              end
            endcase
          end
        end
        SEND: begin
`ifdef LOADER_CHECKSUM_EN
          if (!upgrade) begin
            state <= IDLE;
          end else if (!tx_busy) begin
            tx_valid <= 1'b1;
            tx_data  <= sum;
            state    <= DONE;
            done     <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        DONE: begin
          if (!upgrade) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
